// File: rtl/data_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_ctrl_pkg
// Purpose  : Shared size/state encodings and load-extension helper.
// Revision : 1.0
// ============================================================================
package data_mem_ctrl_pkg;

    localparam int unsigned c_mem_bytes_default = 4096;

    localparam logic [2:0] c_size_b   = 3'b000;
    localparam logic [2:0] c_size_h   = 3'b001;
    localparam logic [2:0] c_size_w   = 3'b010;
    localparam logic [2:0] c_size_d   = 3'b011;
    localparam logic [2:0] c_size_bu  = 3'b100;
    localparam logic [2:0] c_size_hu  = 3'b101;
    localparam logic [2:0] c_size_wu  = 3'b110;
    localparam logic [2:0] c_size_bad = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    // size[2]=1 selects zero extension, size[1:0] the width
    function automatic logic [63:0] extend_load(input logic [63:0] acc, input logic [2:0] size);
        logic s;
        s = ~size[2];
        case (size[1:0])
            2'd0:    extend_load = {{56{s & acc[7]}},  acc[7:0]};
            2'd1:    extend_load = {{48{s & acc[15]}}, acc[15:0]};
            2'd2:    extend_load = {{32{s & acc[31]}}, acc[31:0]};
            default: extend_load = acc;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_ctrl_ram.sv
`default_nettype none
// ============================================================================
// Module   : data_byte_ram
// Purpose  : Single-port byte store, synchronous write, asynchronous read.
// Revision : 1.0
// ============================================================================
module data_byte_ram #(
    parameter int unsigned MEM_BYTES = 4096,
    parameter int unsigned ADDR_W    = $clog2(MEM_BYTES)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] r_mem [MEM_BYTES] = '{default: 8'h00};

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    assign rdata = r_mem[addr];

endmodule
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_ctrl
// Purpose  : Byte-serial load/store controller with legality check and
//            sign/zero extension of load results.
// Revision : 1.0
// ============================================================================
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int unsigned MEM_BYTES = c_mem_bytes_default
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned c_aw         = $clog2(MEM_BYTES);
    localparam logic [63:0] c_mem_bytes64 = 64'(MEM_BYTES);

    state_t            r_state;
    state_t            w_state_next;
    logic [c_aw-1:0]   r_addr;
    logic [63:0]       r_wdata;
    logic              r_we;
    logic [2:0]        r_size;
    logic [2:0]        r_k;
    logic [63:0]       r_acc;
    logic              r_err;

    logic [63:0]       w_req_n;
    logic              w_misaligned;
    logic              w_oob;
    logic              w_illegal;
    logic [2:0]        w_last_k;
    logic              w_ram_we;
    logic [c_aw-1:0]   w_ram_addr;
    logic [7:0]        w_ram_rdata;

    assign w_req_n      = 64'd1 << req_size[1:0];
    assign w_misaligned = (req_addr & (w_req_n - 64'd1)) != 64'd0;
    // Compare against MEM_BYTES-N so addresses near 2^64 cannot wrap past the check
    assign w_oob        = req_addr > (c_mem_bytes64 - w_req_n);
    assign w_illegal    = (req_size == c_size_bad) | (req_we & req_size[2]) | w_misaligned | w_oob;

    assign w_last_k   = 3'((4'd1 << r_size[1:0]) - 4'd1);
    assign w_ram_addr = r_addr + c_aw'(r_k);

    always_comb begin
        w_state_next = r_state;
        w_ram_we     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_state_next = w_illegal ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_ram_we = r_we;
                if (r_k == w_last_k) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_size  <= '0;
            r_k     <= '0;
            r_acc   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_addr[c_aw-1:0];
                        r_wdata <= req_wdata;
                        r_we    <= req_we;
                        r_size  <= req_size;
                        r_k     <= '0;
                        r_acc   <= '0;
                        r_err   <= w_illegal;
                    end
                end
                S_ACCESS: begin
                    r_k <= r_k + 3'd1;
                    if (!r_we) begin
                        r_acc[{r_k, 3'b000} +: 8] <= w_ram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    data_byte_ram #(
        .MEM_BYTES (MEM_BYTES),
        .ADDR_W    (c_aw)
    ) u_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .addr  (w_ram_addr),
        .wdata (r_wdata[{r_k, 3'b000} +: 8]),
        .rdata (w_ram_rdata)
    );

    assign req_ready = (r_state == S_IDLE) & ~rst;
    assign busy      = (r_state != S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_err   = rsp_valid & r_err;
    assign rsp_rdata = (rsp_valid & ~r_we & ~r_err) ? extend_load(r_acc, r_size) : 64'd0;

endmodule
`default_nettype wire

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_BYTES, default 4096, giving the byte capacity of the data store; it must be a power of two.
REQ-002 The block SHALL have port clk, input, 1, the system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset: asynchronous, active-high.
REQ-004 The block SHALL have port req_valid, input, 1, meaning a request is present.
REQ-005 The block SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-006 The block SHALL have port req_size, input, 3, in funct3 encoding: 000 lb/sb, 001 lh/sh, 010 lw/sw, 011 ld/sd, 100 lbu, 101 lhu, 110 lwu.
REQ-007 The block SHALL have port req_addr, input, 64, the byte address.
REQ-008 The block SHALL have port req_wdata, input, 64, the store data; the low bytes are used.
REQ-009 The block SHALL have port req_ready, output, 1, meaning the block can accept a request; a request is accepted on a rising edge with req_valid=1 and req_ready=1.
REQ-010 The block SHALL have port rsp_valid, output, 1, a one-cycle pulse that marks completion of a request.
REQ-011 The block SHALL have port rsp_rdata, output, 64, the extended load result, valid while rsp_valid=1.
REQ-012 The block SHALL have port rsp_err, output, 1, flagging a rejected request, valid while rsp_valid=1.
REQ-013 The block SHALL have port busy, output, 1, high in the ACCESS and RESP states.

Function
REQ-014 The FSM SHALL have the states IDLE, ACCESS and RESP.
REQ-015 req_ready SHALL be 1 only in IDLE with rst=0; req_valid is ignored in every other state.
REQ-016 On acceptance, the block SHALL register addr, wdata, we and size, set byte count N = 1/2/4/8 from size[1:0], clear byte index k, and enter ACCESS.
REQ-017 A request is illegal when any of these holds: size=111; a store with size[2]=1; addr not a multiple of N; addr+N > MEM_BYTES. An illegal request SHALL skip ACCESS, go directly to RESP with rsp_err=1 and rsp_rdata=0, and leave memory untouched.
REQ-018 ACCESS SHALL handle exactly one byte per cycle, little-endian: byte k is mem[addr+k] and corresponds to data bits [8k+7:8k].
REQ-019 For a store, the block SHALL write wdata byte k to mem[addr+k] on the edge ending ACCESS cycle k.
REQ-020 For a load, the block SHALL capture mem[addr+k] into accumulator byte k on the same edge as REQ-019; the memory read is combinational.
REQ-021 k SHALL increment each ACCESS cycle; after the cycle with k=N-1 the FSM goes to RESP.
REQ-022 RESP SHALL last one cycle with rsp_valid=1, then return to IDLE; no back-to-back acceptance occurs in RESP.
REQ-023 Latency: if a request is accepted in cycle C0, rsp_valid SHALL be high in cycle C(N+1) for a legal request and in C1 for an illegal one.
REQ-024 For a load, rsp_rdata SHALL be sign-extended from bit 8N-1 when size[2]=0 and zero-extended when size[2]=1; ld returns all 64 bits.
REQ-025 For a store, rsp_rdata SHALL be 0; rsp_err=0 for every legal request.
REQ-026 rsp_rdata and rsp_err SHALL be 0 whenever rsp_valid=0.
REQ-027 Address arithmetic SHALL use 64-bit compares so that an addr near 2^64 cannot wrap past the range check.
REQ-028 The memory SHALL be zero at time 0 in simulation; it is not cleared by reset.

Reset
REQ-029 On rst=1 the block SHALL, asynchronously, go to IDLE, clear k, the accumulator and the registered request, and drive req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 and busy=0.
REQ-030 If rst asserts mid-store, bytes already written SHALL remain written, no further bytes are written, and no rsp_valid is issued.
REQ-031 After rst deasserts, req_ready SHALL be 1 in the first cycle.

Structure
REQ-032 The size encodings, the state encodings and the MEM_BYTES default SHALL live in the shared defs header.
REQ-033 The byte storage SHALL be one sub-module, data_byte_ram: a MEM_BYTES x 8 array with synchronous write and asynchronous read on a single port.
REQ-034 The FSM, the byte counter, the legality check and the extension logic SHALL reside in data_mem_ctrl.

Verification
REQ-035 The bench SHALL run: sd addr=0x10 wdata=0x8877665544332211, then ld 0x10 -> rsp_rdata=0x8877665544332211, with rsp_valid 9 cycles after each acceptance.
REQ-036 The bench SHALL run: sb 0x20 wdata=0x80; then lb 0x20 -> 0xFFFFFFFFFFFFFF80; then lbu 0x20 -> 0x0000000000000080; rsp_valid 2 cycles after each acceptance.
REQ-037 The bench SHALL run: lw at 0x22 (misaligned) -> rsp_err=1 and rsp_rdata=0 one cycle after acceptance; memory unchanged.
REQ-038 The bench SHALL run: sd at MEM_BYTES-4 -> rsp_err=1, no bytes written; separately, sd at 0xFFFFFFFFFFFFFFF8 -> rsp_err=1.
REQ-039 The bench SHALL run: assert rst in the 3rd ACCESS cycle of sw 0x40 wdata=0xDDCCBBAA over old data 0 -> no rsp_valid; lw 0x40 afterwards -> 0x0000000000BBAA (sign bit 0), and req_ready=1 the cycle after rst falls.
REQ-040 The bench SHALL run: hold req_valid high continuously with two requests -> second accepted only in the IDLE cycle after RESP; req_ready=0 throughout ACCESS and RESP.
